// File: rtl/bram_ring_capture.sv
// Circular BRAM capture buffer: records samples continuously, freezes POST_TRIG samples after a trigger,
// and reads the frozen window back in chronological order (index 0 = oldest).
module bram_ring_capture #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 2096,
  parameter int POST_TRIG = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              arm,
  input  logic              trig,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              armed,
  output logic              done
);

  localparam int PRE = DEPTH - POST_TRIG;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_TRIG - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_LO  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic                armed_q, armed_d;
  logic                done_q, done_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_err_q, rd_err_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                wr_en_s;
  logic [ADDR_W:0]     rd_sum_s;
  logic [ADDR_W-1:0]   rd_phys_s;
  logic                rd_ok_s, rd_bad_s, rd_hit_s;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Capture FSM, counters and write pointer; arm overrides everything except reset.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    post_cnt_d = post_cnt_q;
    case (state_q)
      S_FILL, S_ARMED, S_POST: wr_en_s = s_valid;
      default:                 wr_en_s = 1'b0;
    endcase

    if (arm) begin
      state_d    = S_FILL;
      fill_cnt_d = '0;
      post_cnt_d = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (s_valid) begin
            fill_cnt_d = fill_cnt_q + 1'b1;
            if (fill_cnt_q == PRE_LAST) begin
              state_d = S_ARMED;
            end else begin
              state_d = S_FILL;
            end
          end else begin
            fill_cnt_d = fill_cnt_q;
          end
        end
        S_ARMED: begin
          // The trigger sample is the one accepted now, or the next one if s_valid is low.
          if (trig) begin
            if (s_valid) begin
              post_cnt_d = {{(ADDR_W-1){1'b0}}, 1'b1};
              state_d    = (POST_LAST == '0) ? S_DONE : S_POST;
            end else begin
              post_cnt_d = '0;
              state_d    = S_POST;
            end
          end else begin
            state_d = S_ARMED;
          end
        end
        S_POST: begin
          if (s_valid) begin
            post_cnt_d = post_cnt_q + 1'b1;
            state_d    = (post_cnt_q == POST_LAST) ? S_DONE : S_POST;
          end else begin
            post_cnt_d = post_cnt_q;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end

    if (wr_en_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : (wr_ptr_q + 1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    armed_d = (state_d == S_ARMED);
    done_d  = (state_d == S_DONE);
  end

  // Chronological index to physical address; wr_ptr is the oldest word once frozen.
  always_comb begin
    rd_sum_s = {1'b0, wr_ptr_q} + {1'b0, rd_addr};
    if (rd_sum_s >= DEPTH_W) begin
      rd_phys_s = rd_sum_s[ADDR_W-1:0] - DEPTH_LO;
    end else begin
      rd_phys_s = rd_sum_s[ADDR_W-1:0];
    end
    rd_ok_s    = rd_req && (state_q == S_DONE);
    rd_bad_s   = rd_ok_s && ({1'b0, rd_addr} >= DEPTH_W);
    rd_hit_s   = rd_ok_s && !rd_bad_s;
    rd_valid_d = rd_ok_s;
    rd_err_d   = rd_bad_s;
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      post_cnt_q <= '0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      post_cnt_q <= post_cnt_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem[wr_ptr_q] <= s_data;
    end
  end

  // Registered BRAM read port; holds its value between reads, zero on an out-of-range request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_hit_s) begin
      rd_data_q <= mem[rd_phys_s];
    end else if (rd_bad_s) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign armed    = armed_q;
  assign done     = done_q;

endmodule
